// File: rtl/inst_buffer_pkg.sv
// Shared fetch/dispatch definitions for the instruction buffer.
//   N                  superscalar width (max enqueue/dequeue per cycle)
//   NUM_SCALAR_BITS    width of a 0..N slot count
//   INST_BUFFER_DEPTH  default buffer depth
//   fetch_packet_t     one fetched instruction and its PC
package inst_buffer_pkg;

  localparam int unsigned N                 = 3;
  localparam int unsigned NUM_SCALAR_BITS   = $clog2(N + 1);
  localparam int unsigned INST_BUFFER_DEPTH = 16;
  localparam int unsigned XLEN              = 32;

  typedef logic [XLEN-1:0] inst_t;
  typedef logic [XLEN-1:0] addr_t;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fetch_packet_t;

endpackage

// File: rtl/inst_buffer.sv
// Circular FIFO between fetch and dispatch.
//   clock, reset          clock; synchronous active-high reset
//   flush                 mispredict recovery, drops every entry
//   inst_buffer_inputs    up to N packets from fetch, slot 0 oldest
//   instructions_valid    number of valid input slots
//   inst_buffer_spots     free space offered to fetch, min(DEPTH-count, N)
//   dispatch_packets      oldest entries, slot 0 = head, unused slots zero
//   dispatch_available    occupancy offered to dispatch, min(count, N)
//   dispatch_count        packets dispatch consumes this cycle
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = INST_BUFFER_DEPTH
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  fetch_packet_t [N-1:0]                inst_buffer_inputs,
  input  logic          [NUM_SCALAR_BITS-1:0]  instructions_valid,
  output logic          [NUM_SCALAR_BITS-1:0]  inst_buffer_spots,
  output fetch_packet_t [N-1:0]                dispatch_packets,
  output logic          [NUM_SCALAR_BITS-1:0]  dispatch_available,
  input  logic          [NUM_SCALAR_BITS-1:0]  dispatch_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = NUM_SCALAR_BITS;

  fetch_packet_t r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_free;
  logic [SW-1:0] w_spots, w_avail, w_enq, w_deq;
  logic [PW-1:0] w_head_next, w_tail_next;
  logic [CW-1:0] w_count_next;

  // Outputs depend on registered state only; enq/deq are clamped to what was offered.
  always_comb begin
    w_free             = CW'(DEPTH) - r_count;
    w_spots            = (w_free >= CW'(N)) ? SW'(N) : SW'(w_free);
    w_avail            = (r_count >= CW'(N)) ? SW'(N) : SW'(r_count);
    w_enq              = '0;
    w_deq              = '0;
    w_head_next        = r_head;
    w_tail_next        = r_tail;
    w_count_next       = r_count;
    inst_buffer_spots  = w_spots;
    dispatch_available = w_avail;
    dispatch_packets   = '0;

    for (int i = 0; i < int'(N); i++) begin
      if (SW'(i) < w_avail) dispatch_packets[i] = r_mem[r_head + PW'(i)];
    end

    if (flush) begin
      w_head_next  = '0;
      w_tail_next  = '0;
      w_count_next = '0;
    end else begin
      w_enq        = (instructions_valid > w_spots) ? w_spots : instructions_valid;
      w_deq        = (dispatch_count > w_avail) ? w_avail : dispatch_count;
      w_head_next  = r_head + PW'(w_deq);
      w_tail_next  = r_tail + PW'(w_enq);
      w_count_next = r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Pointer/occupancy state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // Storage is not reset; multi-slot writes may wrap past DEPTH-1 via pointer truncation.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        if (SW'(i) < w_enq) r_mem[r_tail + PW'(i)] <= inst_buffer_inputs[i];
      end
    end
  end

endmodule
